// File: rtl/elevator_input_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : elevator_input_pkg
//  Purpose  : Shared types and default constants for the button input path:
//             the per-channel press FSM state encoding and parameter defaults.
//  Revision : 1.0 - initial release
// ============================================================================
package elevator_input_pkg;

    // Per-channel press state: idle, held after an accepted press, auto-repeating
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } ch_state_t;

    localparam int DEF_N_CH         = 4;
    localparam int DEF_DEBOUNCE_CYC = 4;
    localparam int DEF_REPEAT_EN    = 0;
    localparam int DEF_REPEAT_DLY   = 50;
    localparam int DEF_REPEAT_PER   = 10;

    // Larger of two integers, used to size the hold counter
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_channel.sv
`default_nettype none
// ============================================================================
//  Module   : button_channel
//  Purpose  : One button channel: 2-flop synchronizer, debounce counter and a
//             press/hold/repeat FSM producing registered press/release pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module button_channel
    import elevator_input_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_EN    = DEF_REPEAT_EN,
    parameter int REPEAT_DLY   = DEF_REPEAT_DLY,
    parameter int REPEAT_PER   = DEF_REPEAT_PER
) (
    input  logic Clock,
    input  logic Reset,
    input  logic in,
    output logic press,
    output logic released,
    output logic held
);

    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int HC_W = $clog2(max_int(REPEAT_DLY, REPEAT_PER) + 1);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [HC_W-1:0] DLY_V   = HC_W'(REPEAT_DLY);
    localparam logic [HC_W-1:0] PER_V   = HC_W'(REPEAT_PER);
    localparam logic [HC_W-1:0] HC_ONE  = HC_W'(1);
    localparam logic [HC_W-1:0] HC_MAX  = '1;

    logic            sync_meta;
    logic            sync_out;
    logic [DB_W-1:0] db_cnt;
    logic [HC_W-1:0] hold_cnt;
    ch_state_t       state;
    logic            accept;

    // A level change is accepted on the edge that completes DEBOUNCE_CYC
    // consecutive cycles of disagreement between synchronized input and held.
    assign accept = (sync_out != held) && (db_cnt == DB_LAST);

    // Two-flop synchronizer for the asynchronous button level
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            sync_meta <= in;
            sync_out  <= sync_meta;
        end
    end

    // Debounce, hold timing and press/repeat/release FSM with registered pulses
    always_ff @(posedge Clock) begin
        if (Reset) begin
            db_cnt   <= '0;
            held     <= 1'b0;
            press    <= 1'b0;
            released <= 1'b0;
            hold_cnt <= '0;
            state    <= IDLE;
        end else begin
            press    <= 1'b0;
            released <= 1'b0;

            if (sync_out == held) begin
                db_cnt <= '0;
            end else if (accept) begin
                db_cnt <= '0;
                held   <= ~held;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end

            // Saturating count of cycles since the last press pulse
            if (hold_cnt != HC_MAX) begin
                hold_cnt <= hold_cnt + 1'b1;
            end

            // held is 0 in IDLE and 1 in HELD/REPEAT, so accept alone
            // identifies the direction of the accepted change.
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= HELD;
                        press    <= 1'b1;
                        hold_cnt <= HC_ONE;
                    end
                end
                HELD: begin
                    if (accept) begin
                        state    <= IDLE;
                        released <= 1'b1;
                    end else if ((REPEAT_EN != 0) && (hold_cnt == DLY_V)) begin
                        state    <= REPEAT;
                        press    <= 1'b1;
                        hold_cnt <= HC_ONE;
                    end
                end
                REPEAT: begin
                    // Release takes priority over a repeat due on the same edge
                    if (accept) begin
                        state    <= IDLE;
                        released <= 1'b1;
                    end else if (hold_cnt == PER_V) begin
                        press    <= 1'b1;
                        hold_cnt <= HC_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/button_press_detector.sv
`default_nettype none
// ============================================================================
//  Module   : button_press_detector
//  Purpose  : N_CH independent debounced button channels with press, release
//             and optional auto-repeat pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module button_press_detector
    import elevator_input_pkg::*;
#(
    parameter int N_CH         = DEF_N_CH,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_EN    = DEF_REPEAT_EN,
    parameter int REPEAT_DLY   = DEF_REPEAT_DLY,
    parameter int REPEAT_PER   = DEF_REPEAT_PER
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [N_CH-1:0] in,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] released,
    output logic [N_CH-1:0] held
);

    // One fully independent channel per button
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .REPEAT_EN    (REPEAT_EN),
            .REPEAT_DLY   (REPEAT_DLY),
            .REPEAT_PER   (REPEAT_PER)
        ) u_channel (
            .Clock    (Clock),
            .Reset    (Reset),
            .in       (in[i]),
            .press    (press[i]),
            .released (released[i]),
            .held     (held[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_button_press_detector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_press_detector
//  Purpose  : Directed self-checking bench; one instance without auto-repeat
//             and one with DLY=5/PER=3 auto-repeat, sharing the same inputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_button_press_detector;

    logic       Clock;
    logic       Reset;
    logic [3:0] in;
    logic [3:0] a_press, a_rel, a_held;
    logic [3:0] b_press, b_rel, b_held;

    int tests = 0;
    int fails = 0;

    button_press_detector #(
        .N_CH(4), .DEBOUNCE_CYC(4), .REPEAT_EN(0), .REPEAT_DLY(50), .REPEAT_PER(10)
    ) dut_a (
        .Clock(Clock), .Reset(Reset), .in(in),
        .press(a_press), .released(a_rel), .held(a_held)
    );

    button_press_detector #(
        .N_CH(4), .DEBOUNCE_CYC(4), .REPEAT_EN(1), .REPEAT_DLY(5), .REPEAT_PER(3)
    ) dut_b (
        .Clock(Clock), .Reset(Reset), .in(in),
        .press(b_press), .released(b_rel), .held(b_held)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int         npress;
        logic [3:0] acc;
        logic       exp_p;
        logic       exp_r;

        in    = 4'b0000;
        Reset = 1'b1;

        // Reset state
        tick(); tick(); tick();
        check("rst_a_held",  {28'd0, a_held},  32'd0);
        check("rst_a_press", {28'd0, a_press}, 32'd0);
        check("rst_a_rel",   {28'd0, a_rel},   32'd0);
        check("rst_b_all",   {20'd0, b_held, b_press, b_rel}, 32'd0);
        Reset = 1'b0;
        tick(); tick();

        // Single press on channel 0, no auto-repeat on instance A
        in = 4'b0001;
        repeat (5) tick();
        check("p0_pre_held",  {28'd0, a_held},  32'd0);
        check("p0_pre_press", {28'd0, a_press}, 32'd0);
        tick();
        check("p0_press", {28'd0, a_press}, 32'h1);
        check("p0_held",  {28'd0, a_held},  32'h1);
        tick();
        check("p0_press_end", {28'd0, a_press}, 32'd0);
        npress = 0;
        repeat (20) begin
            tick();
            if (a_press[0]) npress++;
        end
        check("p0_no_repeat", npress, 32'd0);
        check("p0_still_held", {28'd0, a_held}, 32'h1);
        in = 4'b0000;
        repeat (5) tick();
        check("r0_pre_rel", {28'd0, a_rel}, 32'd0);
        tick();
        check("r0_rel",    {28'd0, a_rel},  32'h1);
        check("r0_held",   {28'd0, a_held}, 32'd0);
        check("r0_b_rel",  {28'd0, b_rel},  32'h1);
        tick();
        check("r0_rel_end", {28'd0, a_rel}, 32'd0);
        repeat (4) tick();

        // Three-cycle glitch on channel 1 must be filtered out
        acc = 4'b0000;
        in  = 4'b0010;
        repeat (3) begin
            tick();
            acc = acc | a_press | a_rel | a_held | b_press | b_rel | b_held;
        end
        in = 4'b0000;
        repeat (10) begin
            tick();
            acc = acc | a_press | a_rel | a_held | b_press | b_rel | b_held;
        end
        check("glitch_quiet", {28'd0, acc}, 32'd0);

        // Auto-repeat on channel 2: press at 5, 10, 13, ..., 22; the repeat due
        // at 25 coincides with the accepted release and is suppressed.
        in = 4'b0100;
        for (int k = 0; k < 30; k++) begin
            tick();
            exp_p = (k == 5) || (k >= 10 && k < 25 && ((k - 10) % 3) == 0);
            exp_r = (k == 25);
            check($sformatf("rep_press_k%0d", k), {31'd0, b_press[2]}, {31'd0, exp_p});
            check($sformatf("rep_rel_k%0d", k),   {31'd0, b_rel[2]},   {31'd0, exp_r});
            check($sformatf("norep_press_k%0d", k), {31'd0, a_press[2]}, {31'd0, (k == 5)});
            if (k == 19) in = 4'b0000;
        end

        // Simultaneous press on channels 0 and 3
        in = 4'b1001;
        repeat (5) tick();
        check("sim_pre_press", {28'd0, a_press}, 32'd0);
        tick();
        check("sim_a_press", {28'd0, a_press}, 32'h9);
        check("sim_b_press", {28'd0, b_press}, 32'h9);
        in = 4'b0000;
        repeat (5) tick();
        check("sim_pre_rel", {28'd0, a_rel}, 32'd0);
        tick();
        check("sim_a_rel", {28'd0, a_rel}, 32'h9);
        check("sim_b_rel", {28'd0, b_rel}, 32'h9);
        repeat (6) tick();

        // Reset while channel 1 is held; button stays down through reset
        in = 4'b0010;
        repeat (6) tick();
        check("mid_a_held", {28'd0, a_held}, 32'h2);
        check("mid_b_held", {28'd0, b_held}, 32'h2);
        tick(); tick();
        Reset = 1'b1;
        acc   = 4'b0000;
        repeat (3) begin
            tick();
            check("rst_mid_a_out", {20'd0, a_held, a_press, a_rel}, 32'd0);
            check("rst_mid_b_out", {20'd0, b_held, b_press, b_rel}, 32'd0);
        end
        Reset = 1'b0;
        repeat (5) begin
            tick();
            acc = acc | a_rel | b_rel | a_press | a_held;
        end
        check("post_rst_quiet", {28'd0, acc}, 32'd0);
        tick();
        check("post_rst_a_press", {28'd0, a_press}, 32'h2);
        check("post_rst_a_held",  {28'd0, a_held},  32'h2);
        check("post_rst_b_press", {28'd0, b_press}, 32'h2);
        in = 4'b0000;
        repeat (8) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
